// File: rtl/bus_arbiter_pkg.sv
// bus_arbiter_pkg: FSM encodings and shared constants for the IF/MEM bus arbiter
package bus_arbiter_pkg;
    typedef logic [1:0] state_t;
    localparam state_t S_IDLE     = 2'd0;
    localparam state_t S_IF_WAIT  = 2'd1;
    localparam state_t S_MEM_WAIT = 2'd2;
    localparam int TIMEOUT_DEF = 255;
    localparam logic [15:0] SEL_ALL = '1;
endpackage

// File: rtl/bus_arbiter_if.sv
// bus_arbiter_if: core ports, ctrl handshake and external memory bus of the arbiter
interface bus_arbiter_if #(parameter int ADDR_W = 32, parameter int DATA_W = 32);
    logic                pipe_adv;
    logic                if_req, if_stallreq;
    logic [ADDR_W-1:0]   if_addr;
    logic [DATA_W-1:0]   if_rdata;
    logic                mem_req, mem_we, mem_stallreq;
    logic [DATA_W/8-1:0] mem_sel;
    logic [ADDR_W-1:0]   mem_addr;
    logic [DATA_W-1:0]   mem_wdata, mem_rdata;
    logic                bus_req, bus_we, bus_ack, bus_err;
    logic [DATA_W/8-1:0] bus_sel;
    logic [ADDR_W-1:0]   bus_addr;
    logic [DATA_W-1:0]   bus_wdata, bus_rdata;
    modport master (
        input  pipe_adv, if_req, if_addr, mem_req, mem_we, mem_sel, mem_addr, mem_wdata, bus_rdata, bus_ack,
        output if_rdata, if_stallreq, mem_rdata, mem_stallreq, bus_req, bus_we, bus_sel, bus_addr, bus_wdata, bus_err
    );
    modport slave (
        output pipe_adv, if_req, if_addr, mem_req, mem_we, mem_sel, mem_addr, mem_wdata, bus_rdata, bus_ack,
        input  if_rdata, if_stallreq, mem_rdata, mem_stallreq, bus_req, bus_we, bus_sel, bus_addr, bus_wdata, bus_err
    );
endinterface

// File: rtl/bus_arbiter_timeout_cnt.sv
// bus_arbiter_timeout_cnt: counts unacknowledged wait cycles, hit_o on the TIMEOUT-th one
module bus_arbiter_timeout_cnt #(
    parameter int TIMEOUT = 255
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr_i,
    input  logic en_i,
    output logic hit_o
);
    localparam int CW = $clog2(TIMEOUT + 1);
    logic [CW-1:0] cnt_q, cnt_d;
    assign hit_o = en_i && cnt_q == CW'(TIMEOUT - 1);
    assign cnt_d = (clr_i || hit_o) ? '0 : en_i ? cnt_q + 1'b1 : cnt_q;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) cnt_q <= '0;
        else        cnt_q <= cnt_d;
    end
endmodule

// File: rtl/bus_arbiter.sv
// bus_arbiter: serialises IF fetches and MEM loads/stores onto one registered req/ack bus
module bus_arbiter
    import bus_arbiter_pkg::*;
#(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = TIMEOUT_DEF
) (
    input logic         clk,
    input logic         rst_n,
    bus_arbiter_if.master b
);
    localparam int SW = DATA_W / 8;
    state_t            state_q, state_d;
    logic              bus_req_q, bus_req_d, bus_we_q, bus_we_d, bus_err_q, bus_err_d;
    logic              if_done_q, if_done_d, mem_done_q, mem_done_d;
    logic [SW-1:0]     bus_sel_q, bus_sel_d;
    logic [ADDR_W-1:0] bus_addr_q, bus_addr_d;
    logic [DATA_W-1:0] bus_wdata_q, bus_wdata_d, if_rdata_q, if_rdata_d, mem_rdata_q, mem_rdata_d;
    logic [DATA_W-1:0] rd;
    logic              waiting, hit, fin, if_elig, mem_elig;

    assign if_elig  = b.if_req & ~if_done_q;
    assign mem_elig = b.mem_req & ~mem_done_q;
    assign waiting  = state_q != S_IDLE;
    assign fin      = waiting & (b.bus_ack | hit);
    assign rd       = b.bus_ack ? b.bus_rdata : '0;

    bus_arbiter_timeout_cnt #(.TIMEOUT(TIMEOUT)) u_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .clr_i (~waiting | b.bus_ack),
        .en_i  (waiting & ~b.bus_ack),
        .hit_o (hit)
    );

    always_comb begin
        state_d     = state_q;
        bus_req_d   = bus_req_q;
        bus_we_d    = bus_we_q;
        bus_sel_d   = bus_sel_q;
        bus_addr_d  = bus_addr_q;
        bus_wdata_d = bus_wdata_q;
        if_rdata_d  = if_rdata_q;
        mem_rdata_d = mem_rdata_q;
        bus_err_d   = 1'b0;
        if_done_d   = if_done_q & ~b.pipe_adv;
        mem_done_d  = mem_done_q & ~b.pipe_adv;
        // MEM wins ties: it belongs to the older instruction in the pipe
        if (!waiting && mem_elig) begin
            state_d     = S_MEM_WAIT;
            bus_req_d   = 1'b1;
            bus_we_d    = b.mem_we;
            bus_sel_d   = b.mem_sel;
            bus_addr_d  = b.mem_addr;
            bus_wdata_d = b.mem_wdata;
        end else if (!waiting && if_elig) begin
            state_d     = S_IF_WAIT;
            bus_req_d   = 1'b1;
            bus_we_d    = 1'b0;
            bus_sel_d   = SEL_ALL[SW-1:0];
            bus_addr_d  = b.if_addr;
            bus_wdata_d = '0;
        end else if (fin) begin
            state_d   = S_IDLE;
            bus_req_d = 1'b0;
            bus_err_d = ~b.bus_ack;
            if (state_q == S_IF_WAIT) begin
                if_done_d  = 1'b1;
                if_rdata_d = rd;
            end else begin
                mem_done_d  = 1'b1;
                mem_rdata_d = bus_we_q ? mem_rdata_q : rd;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            bus_req_q   <= 1'b0;
            bus_we_q    <= 1'b0;
            bus_sel_q   <= '0;
            bus_addr_q  <= '0;
            bus_wdata_q <= '0;
            if_rdata_q  <= '0;
            mem_rdata_q <= '0;
            bus_err_q   <= 1'b0;
            if_done_q   <= 1'b0;
            mem_done_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            bus_req_q   <= bus_req_d;
            bus_we_q    <= bus_we_d;
            bus_sel_q   <= bus_sel_d;
            bus_addr_q  <= bus_addr_d;
            bus_wdata_q <= bus_wdata_d;
            if_rdata_q  <= if_rdata_d;
            mem_rdata_q <= mem_rdata_d;
            bus_err_q   <= bus_err_d;
            if_done_q   <= if_done_d;
            mem_done_q  <= mem_done_d;
        end
    end

    assign b.bus_req      = bus_req_q;
    assign b.bus_we       = bus_we_q;
    assign b.bus_sel      = bus_sel_q;
    assign b.bus_addr     = bus_addr_q;
    assign b.bus_wdata    = bus_wdata_q;
    assign b.bus_err      = bus_err_q;
    assign b.if_rdata     = if_rdata_q;
    assign b.mem_rdata    = mem_rdata_q;
    assign b.if_stallreq  = b.if_req & ~if_done_q;
    assign b.mem_stallreq = b.mem_req & ~mem_done_q;
endmodule

// File: tb/tb_bus_arbiter.sv
// tb_bus_arbiter: directed and random transactions against a transaction-level arbiter model
module tb_bus_arbiter;
    localparam int TO = 8;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    bus_arbiter_if b ();
    bus_arbiter #(.TIMEOUT(TO)) dut (.clk(clk), .rst_n(rst_n), .b(b));

    typedef struct {
        logic [31:0] addr;
        logic        we;
        logic [3:0]  sel;
        logic [31:0] wdata;
    } cyc_t;
    cyc_t log_q[$];
    cyc_t exp_q[$];
    cyc_t cur;
    int checks = 0, errors = 0, lat = 1, wcnt = 0, err_cnt = 0;
    logic prev_err = 1'b0;
    logic [31:0] exp_if = '0, exp_mem = '0;

    function automatic logic [31:0] rd_of(input logic [31:0] a);
        return a == 32'h100 ? 32'h24020005 : {a[15:0], ~a[15:0]} ^ 32'h5A5A_0F0F;
    endfunction

    function automatic logic [68:0] pk(input cyc_t c);
        return {c.addr, c.we, c.sel, c.wdata};
    endfunction

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Memory responder: acks on the lat-th cycle of bus_req (lat=0 never acks), logs each cycle
    always @(negedge clk) begin
        b.bus_ack = 1'b0;
        if (b.bus_err) begin
            chk("bus_err_one_cycle", prev_err, 1'b0);
            err_cnt++;
        end
        prev_err = b.bus_err;
        if (b.bus_req) begin
            wcnt++;
            if (wcnt == 1) begin
                cur = '{b.bus_addr, b.bus_we, b.bus_sel, b.bus_wdata};
                log_q.push_back(cur);
            end else
                chk("bus_stable", {b.bus_addr, b.bus_we, b.bus_sel, b.bus_wdata}, pk(cur));
            if (lat != 0 && wcnt == lat) begin
                b.bus_ack   = 1'b1;
                b.bus_rdata = rd_of(b.bus_addr);
            end
        end else
            wcnt = 0;
    end

    task automatic run_txn(input bit di, input logic [31:0] ia, input bit dm, input bit we,
                           input logic [3:0] sel, input logic [31:0] ma, input logic [31:0] wd,
                           input int l, input bit hold);
        int ti = -1;
        int tm = -1;
        int n = 0;
        int e0 = err_cnt;
        int eff = (l == 0) ? TO : l;
        int n_exp = int'(di) + int'(dm);
        log_q.delete();
        exp_q.delete();
        lat = l;
        if (dm) begin
            exp_q.push_back('{ma, we, sel, wd});
            if (!we) exp_mem = (l == 0) ? 32'h0 : rd_of(ma);
        end
        if (di) begin
            exp_q.push_back('{ia, 1'b0, 4'hF, 32'h0});
            exp_if = (l == 0) ? 32'h0 : rd_of(ia);
        end
        b.if_req = di; b.if_addr = ia;
        b.mem_req = dm; b.mem_we = we; b.mem_sel = sel; b.mem_addr = ma; b.mem_wdata = wd;
        while ((ti < 0 || tm < 0) && n < 100) begin
            tick();
            n++;
            if (ti < 0 && !b.if_stallreq) ti = n;
            if (tm < 0 && !b.mem_stallreq) tm = n;
        end
        if (dm) chk("mem_stall_cycles", tm, eff + 1);
        if (di) chk("if_stall_cycles", ti, dm ? 2 * eff + 2 : eff + 1);
        tick();
        tick();
        chk("bus_cycle_count", log_q.size(), n_exp);
        for (int i = 0; i < n_exp && i < log_q.size(); i++) chk("bus_cycle_attr", pk(log_q[i]), pk(exp_q[i]));
        chk("if_rdata", b.if_rdata, exp_if);
        chk("mem_rdata", b.mem_rdata, exp_mem);
        chk("bus_err_count", err_cnt - e0, (l == 0) ? n_exp : 0);
        chk("bus_req_idle", b.bus_req, 1'b0);
        b.pipe_adv = 1'b1;
        tick();
        b.pipe_adv = 1'b0;
        if (!hold) begin
            b.if_req = 1'b0;
            b.mem_req = 1'b0;
        end
    endtask

    initial begin
        b.pipe_adv = 1'b0; b.if_req = 1'b0; b.if_addr = '0;
        b.mem_req = 1'b0; b.mem_we = 1'b0; b.mem_sel = '0; b.mem_addr = '0; b.mem_wdata = '0;
        b.bus_rdata = '0; b.bus_ack = 1'b0;
        #12;
        chk("rst_bus_req", b.bus_req, 1'b0);
        chk("rst_bus_attr", {b.bus_addr, b.bus_we, b.bus_sel, b.bus_wdata}, 69'h0);
        chk("rst_rdata", {b.if_rdata, b.mem_rdata}, 64'h0);
        chk("rst_bus_err", b.bus_err, 1'b0);
        rst_n = 1'b1;
        tick();
        run_txn(1, 32'h100, 0, 0, 4'h0, 32'h0, 32'h0, 1, 0);
        run_txn(1, 32'h104, 1, 0, 4'hF, 32'h2000, 32'h0, 1, 0);
        run_txn(0, 32'h0, 1, 1, 4'b0011, 32'h3000, 32'hDEADBEEF, 3, 0);
        // Reset while a load is stuck in its wait state
        lat = 0;
        b.mem_req = 1'b1; b.mem_we = 1'b0; b.mem_sel = 4'hF; b.mem_addr = 32'h4000;
        tick(); tick(); tick();
        chk("pre_rst_bus_req", b.bus_req, 1'b1);
        #2 rst_n = 1'b0;
        #1;
        chk("async_rst_bus_req", b.bus_req, 1'b0);
        chk("async_rst_bus_err", b.bus_err, 1'b0);
        chk("async_rst_rdata", {b.if_rdata, b.mem_rdata}, 64'h0);
        b.mem_req = 1'b0;
        exp_if = '0;
        exp_mem = '0;
        @(negedge clk) rst_n = 1'b1;
        tick(); tick();
        chk("post_rst_idle", b.bus_req, 1'b0);
        run_txn(1, 32'h200, 0, 0, 4'h0, 32'h0, 32'h0, 0, 0);
        run_txn(1, 32'h104, 0, 0, 4'h0, 32'h0, 32'h0, 1, 1);
        run_txn(1, 32'h104, 0, 0, 4'h0, 32'h0, 32'h0, 1, 0);
        for (int k = 0; k < 24; k++) begin
            bit di = 1'($urandom_range(0, 1));
            bit dm = di ? 1'($urandom_range(0, 1)) : 1'b1;
            run_txn(di, {$urandom_range(0, 32'h3FFF_FFFF), 2'b00}, dm, 1'($urandom_range(0, 1)),
                    4'($urandom_range(1, 15)), {$urandom_range(0, 32'h3FFF_FFFF), 2'b00}, $urandom,
                    $urandom_range(0, 4), 0);
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
